// File: rtl/piso_tx_nbit_if.sv
// piso_tx_nbit_if: load handshake and serial line bundle for the PISO transmitter
interface piso_tx_nbit_if #(parameter int N = 8);
    logic         load_valid_in;
    logic [N-1:0] load_data_in;
    logic         load_ready_out;
    logic         shift_en_in;
    logic         ser_out;
    logic         ser_valid_out;
    logic         frame_start_out;
    logic         busy_out;

    modport master (
        output load_valid_in, load_data_in, shift_en_in,
        input  load_ready_out, ser_out, ser_valid_out, frame_start_out, busy_out
    );

    modport slave (
        input  load_valid_in, load_data_in, shift_en_in,
        output load_ready_out, ser_out, ser_valid_out, frame_start_out, busy_out
    );
endinterface

// File: rtl/piso_tx_nbit.sv
// piso_tx_nbit: N-bit parallel-in/serial-out transmitter with frame-start marker and gapless back-to-back words
module piso_tx_nbit #(
    parameter int N         = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input logic             clk,
    input logic             reset_al_in,
    piso_tx_nbit_if.slave   bus
);
    localparam int CW = (N < 2) ? 1 : $clog2(N);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state, next_state;
    logic [N-1:0]  sreg;
    logic [CW-1:0] cnt;
    logic          last, accept;

    // last bit retires on this edge, so a new word may be taken without a gap
    assign last   = state == SHIFT && cnt == CW'(N - 1) && bus.shift_en_in;
    assign accept = bus.load_valid_in && bus.load_ready_out;

    always_ff @(posedge clk or negedge reset_al_in)
        if (!reset_al_in) state <= IDLE;
        else state <= next_state;

    always_comb
        next_state = accept ? SHIFT : last ? IDLE : state;

    always_comb begin
        bus.load_ready_out  = state == IDLE || last;
        bus.ser_valid_out   = state == SHIFT;
        bus.busy_out        = state == SHIFT;
        bus.frame_start_out = state == SHIFT && cnt == '0;
        bus.ser_out         = state == SHIFT && (LSB_FIRST ? sreg[0] : sreg[N-1]);
    end

    always_ff @(posedge clk or negedge reset_al_in)
        if (!reset_al_in) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (accept) begin
            sreg <= bus.load_data_in;
            cnt  <= '0;
        end else if (last) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (state == SHIFT && bus.shift_en_in) begin
            sreg <= LSB_FIRST ? sreg >> 1 : sreg << 1;
            cnt  <= cnt + 1'b1;
        end
endmodule

// File: tb/tb_piso_tx_nbit.sv
// tb_piso_tx_nbit: scoreboard plus vector-table bench for LSB-first and MSB-first 4-bit transmitters
module tb_piso_tx_nbit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    piso_tx_nbit_if #(.N(4)) bus_a ();
    piso_tx_nbit_if #(.N(4)) bus_b ();

    piso_tx_nbit #(.N(4), .LSB_FIRST(1'b1)) dut_a (.clk(clk), .reset_al_in(rst_n), .bus(bus_a));
    piso_tx_nbit #(.N(4), .LSB_FIRST(1'b0)) dut_b (.clk(clk), .reset_al_in(rst_n), .bus(bus_b));

    assign bus_b.load_valid_in = bus_a.load_valid_in;
    assign bus_b.load_data_in  = bus_a.load_data_in;
    assign bus_b.shift_en_in   = bus_a.shift_en_in;

    always #5 clk = ~clk;

    typedef struct packed {logic en, ser, fs, sv, rdy;} vec_t;

    logic [1:0] q_a[$];
    logic [1:0] q_b[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // expected bits are queued on every accept edge as {frame_start, bit}
    always @(posedge clk) begin
        if (rst_n && bus_a.load_valid_in && bus_a.load_ready_out)
            for (int i = 0; i < 4; i++) q_a.push_back({i == 0, bus_a.load_data_in[i]});
        if (rst_n && bus_b.load_valid_in && bus_b.load_ready_out)
            for (int i = 0; i < 4; i++) q_b.push_back({i == 0, bus_b.load_data_in[3-i]});
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q_a.delete();
            q_b.delete();
        end else begin
            chk("a_valid", bus_a.ser_valid_out, q_a.size() != 0);
            chk("a_busy", bus_a.busy_out, q_a.size() != 0);
            chk("a_ser", bus_a.ser_out, q_a.size() != 0 ? q_a[0][0] : 1'b0);
            chk("a_fs", bus_a.frame_start_out, q_a.size() != 0 ? q_a[0][1] : 1'b0);
            if (q_a.size() != 0 && bus_a.shift_en_in) void'(q_a.pop_front());
            chk("b_valid", bus_b.ser_valid_out, q_b.size() != 0);
            chk("b_busy", bus_b.busy_out, q_b.size() != 0);
            chk("b_ser", bus_b.ser_out, q_b.size() != 0 ? q_b[0][0] : 1'b0);
            chk("b_fs", bus_b.frame_start_out, q_b.size() != 0 ? q_b[0][1] : 1'b0);
            if (q_b.size() != 0 && bus_b.shift_en_in) void'(q_b.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] d);
        bus_a.load_valid_in = 1'b1;
        bus_a.load_data_in  = d;
        step();
        bus_a.load_valid_in = 1'b0;
    endtask

    initial begin
        vec_t tv[8];
        logic sa[8], sb[8], fs8[8];
        logic sa4[4], sb4[4], fs4[4];
        tv[0] = 5'b1_0_1_1_0;
        tv[1] = 5'b0_1_0_1_0;
        tv[2] = 5'b0_1_0_1_0;
        tv[3] = 5'b1_1_0_1_0;
        tv[4] = 5'b1_1_0_1_0;
        tv[5] = 5'b0_0_0_1_0;
        tv[6] = 5'b1_0_0_1_1;
        tv[7] = 5'b0_0_0_0_1;

        bus_a.load_valid_in = 1'b0;
        bus_a.load_data_in  = '0;
        bus_a.shift_en_in   = 1'b0;
        #12;
        chk("rst_ready", bus_a.load_ready_out, 1'b1);
        chk("rst_valid", bus_a.ser_valid_out, 1'b0);
        chk("rst_ser", bus_a.ser_out, 1'b0);
        chk("rst_fs", bus_a.frame_start_out, 1'b0);
        chk("rst_busy", bus_a.busy_out, 1'b0);
        step();
        rst_n = 1'b1;
        step();

        // single word, enable held high
        sa4 = '{1'b1, 1'b1, 1'b0, 1'b1};
        sb4 = '{1'b1, 1'b0, 1'b1, 1'b1};
        fs4 = '{1'b1, 1'b0, 1'b0, 1'b0};
        bus_a.shift_en_in = 1'b1;
        load(4'b1011);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("w1_ser_a", bus_a.ser_out, sa4[c]);
            chk("w1_ser_b", bus_b.ser_out, sb4[c]);
            chk("w1_fs", bus_a.frame_start_out, fs4[c]);
            chk("w1_ready", bus_a.load_ready_out, c == 3);
            step();
        end
        @(negedge clk);
        chk("w1_idle_ser", bus_a.ser_out, 1'b0);
        chk("w1_idle_valid", bus_a.ser_valid_out, 1'b0);
        step();

        // back-to-back: valid held, data changes mid-frame and must be ignored until the last-bit edge
        sa = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        sb = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        fs8 = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        bus_a.load_valid_in = 1'b1;
        bus_a.load_data_in  = 4'hA;
        step();
        bus_a.load_data_in  = 4'h5;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("b2b_ser_a", bus_a.ser_out, sa[c]);
            chk("b2b_ser_b", bus_b.ser_out, sb[c]);
            chk("b2b_fs", bus_a.frame_start_out, fs8[c]);
            chk("b2b_valid", bus_a.ser_valid_out, 1'b1);
            step();
            if (c == 3) bus_a.load_valid_in = 1'b0;
        end
        step();

        // enable gaps stretch bits; ready only on an enabled last-bit edge
        bus_a.shift_en_in = 1'b0;
        load(4'b0110);
        for (int i = 0; i < 8; i++) begin
            bus_a.shift_en_in = tv[i].en;
            @(negedge clk);
            chk("tv_ser", bus_a.ser_out, tv[i].ser);
            chk("tv_fs", bus_a.frame_start_out, tv[i].fs);
            chk("tv_valid", bus_a.ser_valid_out, tv[i].sv);
            chk("tv_ready", bus_a.load_ready_out, tv[i].rdy);
            step();
        end

        // asynchronous reset after two bits of 4'hF
        bus_a.shift_en_in = 1'b1;
        load(4'hF);
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("ar_ser", bus_a.ser_out, 1'b0);
        chk("ar_valid", bus_a.ser_valid_out, 1'b0);
        chk("ar_busy", bus_a.busy_out, 1'b0);
        chk("ar_fs", bus_a.frame_start_out, 1'b0);
        chk("ar_ready", bus_a.load_ready_out, 1'b1);
        bus_a.load_valid_in = 1'b1;
        bus_a.load_data_in  = 4'h3;
        step();
        chk("ar_noaccept", bus_a.ser_valid_out, 1'b0);
        bus_a.load_valid_in = 1'b0;
        rst_n = 1'b1;
        step();
        sa4 = '{1'b1, 1'b1, 1'b0, 1'b0};
        sb4 = '{1'b0, 1'b0, 1'b1, 1'b1};
        load(4'h3);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("ar_ser_a", bus_a.ser_out, sa4[c]);
            chk("ar_ser_b", bus_b.ser_out, sb4[c]);
            chk("ar_fs", bus_a.frame_start_out, fs4[c]);
            step();
        end
        step();
        step();
        chk("drain_a", q_a.size(), 0);
        chk("drain_b", q_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/piso_tx_nbit.md
Name: piso_tx_nbit

Overview:
- Parallel-in/serial-out transmitter. Accepts an N-bit word over a valid/ready handshake and shifts it out one bit per enabled clock.
- Serves as the transmit end feeding the team's serial-in shift-register chains. Provides a frame-start marker so the receiving side can align words.
- Supports back-to-back words with no idle bit between frames.

Parameters:
- N, 8, word width in bits; legal range 2..32.
- LSB_FIRST, 1, 1 = bit 0 transmitted first; 0 = bit N-1 transmitted first.

Ports:
- clk  input  1  rising-edge clock.
- reset_al_in  input  1  asynchronous, active-low reset.
- load_valid_in  input  1  parallel word available.
- load_data_in  input  N  parallel word; sampled only on an accept edge.
- load_ready_out  output  1  transmitter can accept a word this cycle.
- shift_en_in  input  1  bit-rate enable; the serial bit advances only on edges where this is 1.
- ser_out  output  1  serial data.
- ser_valid_out  output  1  ser_out carries a frame bit.
- frame_start_out  output  1  high while ser_out carries the first bit of a word.
- busy_out  output  1  frame in progress (same as ser_valid_out).

Behaviour:
- Reset (reset_al_in = 0, asynchronous):
  - state = IDLE; shift register = 0; bit counter = 0.
  - ser_out = 0, ser_valid_out = 0, frame_start_out = 0, busy_out = 0.
  - load_ready_out = 1, driven combinationally from IDLE.
- Release of reset is synchronous to the next clk edge. No word is accepted on the edge where reset is low.
- States: IDLE and SHIFT.
- Accept event: rising edge with load_valid_in = 1 and load_ready_out = 1.
  - Captures load_data_in into the shift register and sets the counter to 0.
  - Moves or stays in SHIFT.
- load_ready_out:
  - 1 in IDLE.
  - In SHIFT, 1 only when counter = N-1 and shift_en_in = 1, i.e. the last bit is being retired this edge.
  - Otherwise 0.
  - Combinational from state, counter and shift_en_in.
- IDLE:
  - ser_out = 0 and ser_valid_out = 0.
  - On accept, go to SHIFT.
  - Latency: the first bit appears on ser_out in the cycle immediately after the accept edge.
- SHIFT:
  - ser_out = sreg[0] when LSB_FIRST = 1, else sreg[N-1].
  - ser_valid_out = 1.
  - frame_start_out = 1 iff counter = 0.
- Edge in SHIFT with shift_en_in = 0: no change; the current bit is held for arbitrarily many cycles.
- Edge in SHIFT with shift_en_in = 1 and counter < N-1:
  - Shift the register one place toward the output end (zero-fill).
  - Increment the counter.
- Edge in SHIFT with shift_en_in = 1 and counter = N-1:
  - If load_valid_in = 1: accept the new word, stay in SHIFT, counter = 0. The next frame's first bit follows with no gap.
  - Else: go to IDLE and clear the shift register.
- A word occupies exactly N enabled edges on the line.
- Each bit is visible for at least one cycle. Gaps in shift_en_in stretch bits and never drop or duplicate them.
- load_data_in is ignored whenever load_ready_out = 0. A held load_valid_in is not consumed until accept.
- Counter width: clog2(N), minimum 1. The counter never exceeds N-1.
- Shift register assignments: all updates use non-blocking assignments, and each edge performs exactly one whole-register update. Never split a shift and a bit-insert into two assignments to the same register.
- Reset mid-frame:
  - Outputs return to their reset values immediately.
  - The partial word is discarded and not resumed.
  - The next accept starts a fresh frame.

Test Plan:
- N=4, LSB_FIRST=1, shift_en_in held 1; load 4'b1011 at edge 0 -> over cycles 1..4: ser_out = 1,1,0,1; frame_start_out = 1,0,0,0; ser_valid_out = 1; load_ready_out = 1 only in cycle 4; IDLE with ser_out = 0 in cycle 5.
- N=4, LSB_FIRST=0; load 4'b1011 -> ser_out = 1,0,1,1.
- Back-to-back, N=4, LSB_FIRST=1: load_valid_in held with 4'hA, then 4'h5 accepted at the last-bit edge -> ser_out = 0,1,0,1,1,0,1,0 continuously, frame_start_out in cycles 1 and 5, no idle cycle between frames.
- shift_en_in pattern 1,0,0,1,1,0,1 with word 4'b0110 -> each bit held while shift_en_in = 0; sequence still 0,1,1,0; load_ready_out never asserts on a shift_en_in = 0 cycle.
- Reset asserted asynchronously mid-clock after 2 bits of 4'hF -> ser_out, ser_valid_out and busy_out drop to 0 without a clock edge; after release, load 4'h3 -> ser_out = 1,1,0,0 with frame_start_out on the first bit.
- load_valid_in = 1 while busy with a different load_data_in -> data not captured; the current frame completes unaltered.
